// File: rtl/seven_seg_scan_driver_if.sv
`timescale 1ns/1ps
// Bundle of display-driver signals: digit data, load strobe, blanking controls
// and the registered segment/digit-select/frame outputs.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_blank;
  logic [6:0]              seven_seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output digits_in, load, blank_mask, lz_blank,
    input  seven_seg, digit_en, frame_done
  );

  modport slave (
    input  digits_in, load, blank_mask, lz_blank,
    output seven_seg, digit_en, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
`timescale 1ns/1ps
// Multiplexed seven-segment scanner: double-buffered hex digits, per-digit and
// leading-zero blanking, registered segment/select outputs and frame pulse.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input logic                    clk,
  input logic                    rst,
  seven_seg_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int ACT_W = 4 * NUM_DIGITS;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'b1111110;
      4'h1:    hex_to_seg = 7'b0110000;
      4'h2:    hex_to_seg = 7'b1101101;
      4'h3:    hex_to_seg = 7'b1111001;
      4'h4:    hex_to_seg = 7'b0110011;
      4'h5:    hex_to_seg = 7'b1011011;
      4'h6:    hex_to_seg = 7'b1011111;
      4'h7:    hex_to_seg = 7'b1110000;
      4'h8:    hex_to_seg = 7'b1111111;
      4'h9:    hex_to_seg = 7'b1111011;
      4'hA:    hex_to_seg = 7'b1110111;
      4'hB:    hex_to_seg = 7'b0011111;
      4'hC:    hex_to_seg = 7'b1001110;
      4'hD:    hex_to_seg = 7'b0111101;
      4'hE:    hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACT_W-1:0]      active_q, active_d;
  logic [ACT_W-1:0]      pending_q, pending_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fdone_q, fdone_d;

  logic                  step, wrap, lz_run, cur_blank;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] zero_above;

  always_comb begin
    step       = (pre_q == PRE_LAST);
    wrap       = step && (idx_q == IDX_LAST);
    pre_d      = step ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    if (step) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // A load landing on the wrap edge bypasses the pending buffer entirely.
    if (wrap) begin
      if (bus.load) begin
        active_d   = bus.digits_in;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        active_d   = pending_q;
        pend_vld_d = 1'b0;
      end
    end else if (bus.load) begin
      pending_d  = bus.digits_in;
      pend_vld_d = 1'b1;
    end

    // zero_above[k]: active digits k..NUM_DIGITS-1 are all zero.
    lz_run     = 1'b1;
    zero_above = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run        = lz_run && (active_q[4*k +: 4] == 4'h0);
      zero_above[k] = lz_run;
    end

    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = active_q[4*k +: 4];
        cur_blank = bus.blank_mask[k] | (bus.lz_blank & zero_above[k] & (k != 0));
      end
    end

    seg_d   = cur_blank ? 7'b0000000 : hex_to_seg(cur_nib);
    en_d    = NUM_DIGITS'(1) << idx_q;
    fdone_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= '0;
      en_q       <= '0;
      fdone_q    <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      en_q       <= en_d;
      fdone_q    <= fdone_d;
    end
  end

  assign bus.seven_seg  = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = fdone_q;

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 4, clock cycles each digit is driven; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 digits_in  input  4*NUM_DIGITS  hex digit values; digit k = digits_in[4k+3:4k]; digit 0 = least significant, rightmost.
REQ-006 load  input  1  capture digits_in this cycle.
REQ-007 blank_mask  input  NUM_DIGITS  bit k = 1 forces digit k dark; sampled live, not captured.
REQ-008 lz_blank  input  1  enables leading-zero blanking; sampled live.
REQ-009 seven_seg  output  7  segments {a,b,c,d,e,f,g}, active-high, registered.
REQ-010 digit_en  output  NUM_DIGITS  one-hot digit select, active-high, registered.
REQ-011 frame_done  output  1  one-cycle pulse, registered, marks end of a full scan.

Function
REQ-012 Decode SHALL map 0-9 as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-013 Decode SHALL map A-F as: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; no input code is invalid.
REQ-014 Prescaler counts 0..REFRESH_DIV-1, wraps to 0; digit index idx advances by 1 on the edge where prescaler = REFRESH_DIV-1.
REQ-015 idx wraps from NUM_DIGITS-1 to 0 (the wrap edge); full frame = NUM_DIGITS*REFRESH_DIV cycles.
REQ-016 Outputs registered: seven_seg, digit_en, frame_done in cycle n+1 reflect idx, prescaler, active digits, blank_mask, lz_blank in cycle n.
REQ-017 digit_en SHALL have exactly bit idx set every cycle after the first post-reset edge, including when the digit is blanked.
REQ-018 Blanked digit SHALL drive seven_seg = 0000000.
REQ-019 Digit k blanked if blank_mask[k] = 1, or lz_blank = 1 and active digits k..NUM_DIGITS-1 are all zero and k != 0.
REQ-020 Digit 0 SHALL never be leading-zero blanked (value 0 shows as 1111110 unless blank_mask[0] = 1).
REQ-021 Double buffering: load = 1 writes digits_in to pending register and sets pending_valid.
REQ-022 On the wrap edge with pending_valid = 1: active <= pending, pending_valid cleared.
REQ-023 load = 1 on the wrap edge: digits_in written directly to active and pending_valid cleared (load wins over older pending data).
REQ-024 Multiple loads within one frame: last load wins; active never changes except on a wrap edge.
REQ-025 frame_done = 1 in the cycle after each wrap edge, 0 otherwise.
REQ-026 REFRESH_DIV = 1: idx advances every cycle; NUM_DIGITS = 1: every advance is a wrap edge, digit_en constant 1.

Reset
REQ-027 rst = 1 at an edge: prescaler, idx, active, pending, pending_valid cleared; seven_seg = 0000000, digit_en = all 0, frame_done = 0 the following cycle.
REQ-028 rst SHALL override load and any in-progress frame; pending data is discarded.
REQ-029 First edge after rst deasserts: digit_en = 0001, idx = 0, prescaler restarts at 0.

Verification (NUM_DIGITS = 4, REFRESH_DIV = 4 unless stated)
REQ-030 Reset, no load, masks 0, lz_blank 0 -> every digit shows 1111110; digit_en sequence 0001,0010,0100,1000 each 4 cycles; frame_done pulses every 16 cycles.
REQ-031 load with digits_in = 16'hA3F0 mid-frame -> active unchanged until wrap; next frame shows digit0 1111110, digit1 1000111, digit2 1111001, digit3 1110111.
REQ-032 Active = 16'h0050, lz_blank 1 -> digits 3,2 dark (0000000) with digit_en still cycling; digit1 1011011, digit0 1111110. Active = 16'h0000 -> only digit0 lit, 1111110.
REQ-033 load 16'h1111 then load 16'h2222 in same frame, plus load 16'h3333 on the wrap edge of a later frame -> frame after first wrap shows all 1101101; 16'h3333 shown from the cycle after its wrap edge.
REQ-034 blank_mask = 4'b0101, active = 16'h8888 -> digits 0,2 output 0000000, digits 1,3 output 1111111.
REQ-035 rst asserted mid-frame with pending_valid = 1 -> outputs zero next cycle; after release all digits show 1111110; pending value never appears.
